cpu_opponent: RTL and testbench
===============================

# cpu_opponent

Computer-controlled fighter that drives one player's 7-bit button vector into `game` in place of physical buttons, closing the loop on the game's player-input interface. It reads the positions, health, shield and actions the game publishes. It then produces move, jump, shield and attack presses from a decision FSM paced by a decision timer and a pseudo-random source. Attack presses are shaped long enough to survive the game's attack debouncer.

## Interface
- `DECIDE_PERIOD`, 2_000_000: clocks between decision strobes (20 ms at 100 MHz).
- `ATTACK_HOLD`, 1_500_000: clocks the attack bit is held high.
- `ATTACK_GAP`, 1_500_000: clocks the attack bit is held low after a hold.
- `ATTACK_RANGE`, 80: horizontal distance below which the opponent is in reach (the character width).
- `LOW_HEALTH`, 4: health below which retreat is allowed.
- `SEED`, 16'hACE1: LFSR reset value. A value of zero is replaced by 16'h0001.
- `clk`, in, 1: system clock. This is the single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: 1 = CPU controls this player; 0 = outputs forced idle.
- `self_x`, `self_y`, in, 10 each: top-left pixel of the controlled player.
- `opp_x`, `opp_y`, in, 10 each: top-left pixel of the opponent.
- `self_health`, in, 4: health of the controlled player.
- `self_shield`, in, 4: shield of the controlled player.
- `opp_action`, in, 7: opponent action. Bit 6 is facing; bits 5:0 are the action code.
- `finish`, in, 2: game-over status. Bit 0 = game over.
- `cpu_inputs`, out, 7: registered button vector with bits {shield, attack, down, up, right, left, center} = [6:0].
- `cpu_state`, out, 3: current FSM state, for debug LEDs.

## Operation
- **Decision timer.** Counts 0..DECIDE_PERIOD-1 and wraps. `strobe` is asserted for 1 clock on the wrap.
- **LFSR.** 16-bit Fibonacci with taps 16, 14, 13, 11. It advances every clock.
- **Distance.** `dist` = |self_x − opp_x|, 10-bit unsigned, computed without wrap.
  - `near` = dist < ATTACK_RANGE.
  - `dir_r` = opp_x > self_x.
- **States:**
  - IDLE = 0: outputs all 0.
  - APPROACH = 1: bit 2 if `dir_r`, else bit 1.
  - ATTACK = 2: runs ATTACK_HOLD clocks with bit 5 = 1, then ATTACK_GAP clocks with bit 5 = 0. The state is not re-evaluated on a strobe. At the end of the gap it goes to IDLE.
  - GUARD = 3: bit 6 = 1.
  - RETREAT = 4: bit 1 if `dir_r`, else bit 2.
  - JUMP = 5: bit 3 = 1.
- **Decision on strobe** (from any state except ATTACK; first match wins):
  1. finish[0] or !enable → IDLE.
  2. !near → APPROACH, except lfsr[2:0]==0 → JUMP.
  3. near and opp_action[5:0]==ATTACK_CODE and self_shield≠0 and lfsr[0] → GUARD.
  4. near and self_health<LOW_HEALTH and lfsr[2:1]==0 → RETREAT.
     - If retreat is blocked by a wall (self_x ≤ X_MIN moving left, or self_x ≥ X_MAX−CHAR_WIDTH moving right) → GUARD instead.
  5. Otherwise → ATTACK.
- **Immediate abort.** finish[0]=1 or enable=0 forces IDLE on the next clock from any state, including mid-ATTACK. The attack counter clears. This abort has priority over the strobe.
- **Exclusivity.** Left and right are never asserted together. Bit 0 (center) and bit 4 (down) are always 0.

## Timing
- **Reset values:**
  - `cpu_inputs` = 0, `cpu_state` = IDLE.
  - Timer = 0, attack counter = 0, LFSR = SEED.
- **Latency.** `cpu_inputs` reflects a decision 1 clock after the strobe.
- **Inputs.** All inputs are sampled on the strobe clock; no input register is needed (the game updates them slowly).
- **ATTACK timing.** Exactly ATTACK_HOLD+ATTACK_GAP clocks from entry to IDLE. A strobe that arrives during ATTACK is dropped, not queued.
- **Reset mid-ATTACK.** Reset returns all values to their reset state on the next clock.

## Structure
- **Shared package `game_pkg`:**
  - Button bit indices: CENTER=0, LEFT=1, RIGHT=2, UP=3, DOWN=4, ATTACK=5, SHIELD=6.
  - SHIELD_CODE = 6'b000100, ATTACK_CODE = 6'b001000.
  - X_MIN = 143, X_MAX = 784, CHAR_WIDTH = 80, GROUND_Y = 300.
- **State encoding.** FSM state is a localparam set in `cpu_opponent`.
- **Sub-module `lfsr16`.** Ports: clk, reset, seed, q[15:0].

## Test plan
Use DECIDE_PERIOD=8, ATTACK_HOLD=4, ATTACK_GAP=4, SEED=16'hACE1 unless a scenario sets otherwise.
1. Hold reset, then release with enable=1, self_x=200, opp_x=600, finish=0, and a seed that gives lfsr[2:0]≠0 at the first strobe → cpu_inputs=0 for 8 clocks, then 7'b0000100 one clock after the strobe.
2. self_x=200, opp_x=250, opp_action=0, health=15 → on strobe enter ATTACK; bit 5 high for exactly 4 clocks, low for 4 clocks, then state IDLE. A strobe arriving mid-attack does not change the output.
3. Near, opp_action[5:0]=6'b001000, self_shield=3, lfsr[0]=1 at the strobe → cpu_inputs=7'b1000000.
   - Same with self_shield=0 → ATTACK.
4. Near, self_health=2, lfsr[2:1]=0, opp_x=150, self_x=143 → RETREAT is blocked by the wall, so the result is GUARD (7'b1000000).
5. Raise finish[0] 2 clocks into an ATTACK hold → cpu_inputs=0 and state IDLE on the next clock; later strobes keep IDLE.
6. Over 10,000 clocks of random stimulus, check that bits 1 and 2 are never both 1 and that bits 0 and 4 are always 0.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Constants shared between the game and its player-input
//                sources: button bit indices, action codes and arena limits,
//                plus small helpers used by the CPU opponent.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package game_pkg;

  // Button bit positions inside the 7-bit player input vector
  localparam int CENTER = 0;
  localparam int LEFT   = 1;
  localparam int RIGHT  = 2;
  localparam int UP     = 3;
  localparam int DOWN   = 4;
  localparam int ATTACK = 5;
  localparam int SHIELD = 6;

  // Action codes published in bits 5:0 of a player's action word
  localparam logic [5:0] SHIELD_CODE = 6'b000100;
  localparam logic [5:0] ATTACK_CODE = 6'b001000;

  // Arena geometry in pixels
  localparam logic [9:0] X_MIN      = 10'd143;
  localparam logic [9:0] X_MAX      = 10'd784;
  localparam logic [9:0] CHAR_WIDTH = 10'd80;
  localparam logic [9:0] GROUND_Y   = 10'd300;

  // One-hot button vector with only bit idx set
  function automatic logic [6:0] btn(input int idx);
    return 7'b0000001 << idx;
  endfunction

  // |a - b| without wrap-around
  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_opponent_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr16
//  Description : 16-bit Fibonacci LFSR, taps 16/14/13/11, advancing every
//                clock. An all-zero seed would lock the register, so it is
//                replaced by 16'h0001 at reset.
//  Ports       : clk   - system clock
//                reset - synchronous active-high reset (loads seed)
//                seed  - reset value
//                q     - current register contents
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic        w_fb;

  assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= (seed == 16'h0000) ? 16'h0001 : seed;
    end else begin
      r_q <= {r_q[14:0], w_fb};
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/cpu_opponent.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_opponent
//  Description : Computer-controlled fighter. Every DECIDE_PERIOD clocks it
//                picks a move from the published game state and a
//                pseudo-random source, and drives a registered 7-bit button
//                vector in place of physical buttons. Attack presses are
//                stretched to ATTACK_HOLD high + ATTACK_GAP low.
//  Ports       : clk, reset              - clock, sync active-high reset
//                enable                  - 1 = CPU drives this player
//                self_x/self_y           - controlled player position
//                opp_x/opp_y             - opponent position
//                self_health/self_shield - controlled player status
//                opp_action              - opponent facing + action code
//                finish                  - bit 0 = game over
//                cpu_inputs              - {shield,attack,down,up,right,left,center}
//                cpu_state               - current FSM state (debug)
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_opponent
  import game_pkg::*;
#(
  parameter int          DECIDE_PERIOD = 2_000_000,
  parameter int          ATTACK_HOLD   = 1_500_000,
  parameter int          ATTACK_GAP    = 1_500_000,
  parameter int          ATTACK_RANGE  = 80,
  parameter int          LOW_HEALTH    = 4,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] self_x,
  input  logic [9:0] self_y,
  input  logic [9:0] opp_x,
  input  logic [9:0] opp_y,
  input  logic [3:0] self_health,
  input  logic [3:0] self_shield,
  input  logic [6:0] opp_action,
  input  logic [1:0] finish,
  output logic [6:0] cpu_inputs,
  output logic [2:0] cpu_state
);

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_APPROACH = 3'd1;
  localparam logic [2:0] c_ST_ATTACK   = 3'd2;
  localparam logic [2:0] c_ST_GUARD    = 3'd3;
  localparam logic [2:0] c_ST_RETREAT  = 3'd4;
  localparam logic [2:0] c_ST_JUMP     = 3'd5;

  localparam int c_TW = (DECIDE_PERIOD > 1) ? $clog2(DECIDE_PERIOD) : 1;
  localparam int c_CW = ((ATTACK_HOLD + ATTACK_GAP) > 1) ? $clog2(ATTACK_HOLD + ATTACK_GAP) : 1;
  localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(DECIDE_PERIOD - 1);
  localparam logic [c_CW-1:0] c_ATK_LAST   = c_CW'(ATTACK_HOLD + ATTACK_GAP - 1);
  localparam logic [c_CW-1:0] c_HOLD_LAST  = c_CW'(ATTACK_HOLD - 1);

  logic [c_TW-1:0] r_timer;
  logic [c_CW-1:0] r_atk_cnt;
  logic [2:0]      r_state;
  logic [6:0]      r_buttons;

  logic [15:0] w_lfsr;
  logic        w_strobe;
  logic        w_abort;
  logic [9:0]  w_dist;
  logic        w_near;
  logic        w_dir_r;
  logic        w_wall_block;
  logic [2:0]  w_dec_state;
  logic [6:0]  w_dec_buttons;
  logic        w_unused;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED),
    .q     (w_lfsr)
  );

  // Free-running decision timer; the strobe marks its wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= '0;
    end else begin
      r_timer <= (r_timer == c_TIMER_LAST) ? '0 : r_timer + 1'b1;
    end
  end

  assign w_strobe = (r_timer == c_TIMER_LAST);
  assign w_abort  = finish[0] | ~enable;
  assign w_dist   = abs_diff(self_x, opp_x);
  assign w_near   = (w_dist < 10'(ATTACK_RANGE));
  assign w_dir_r  = (opp_x > self_x);

  // Retreat runs away from the opponent: left when it is to our right
  assign w_wall_block = w_dir_r ? (self_x <= X_MIN) : (self_x >= (X_MAX - CHAR_WIDTH));

  // Decision taken when a strobe lands outside ATTACK; first match wins
  always_comb begin
    w_dec_state   = c_ST_ATTACK;
    w_dec_buttons = btn(ATTACK);
    if (w_abort) begin
      w_dec_state   = c_ST_IDLE;
      w_dec_buttons = '0;
    end else if (!w_near) begin
      if (w_lfsr[2:0] == 3'b000) begin
        w_dec_state   = c_ST_JUMP;
        w_dec_buttons = btn(UP);
      end else begin
        w_dec_state   = c_ST_APPROACH;
        w_dec_buttons = w_dir_r ? btn(RIGHT) : btn(LEFT);
      end
    end else if ((opp_action[5:0] == ATTACK_CODE) && (self_shield != 4'd0) && w_lfsr[0]) begin
      w_dec_state   = c_ST_GUARD;
      w_dec_buttons = btn(SHIELD);
    end else if ((self_health < 4'(LOW_HEALTH)) && (w_lfsr[2:1] == 2'b00)) begin
      if (w_wall_block) begin
        w_dec_state   = c_ST_GUARD;
        w_dec_buttons = btn(SHIELD);
      end else begin
        w_dec_state   = c_ST_RETREAT;
        w_dec_buttons = w_dir_r ? btn(LEFT) : btn(RIGHT);
      end
    end
  end

  // Abort beats everything; ATTACK ignores strobes until its gap expires
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_ST_IDLE;
      r_buttons <= '0;
      r_atk_cnt <= '0;
    end else if (w_abort) begin
      r_state   <= c_ST_IDLE;
      r_buttons <= '0;
      r_atk_cnt <= '0;
    end else if (r_state == c_ST_ATTACK) begin
      if (r_atk_cnt == c_ATK_LAST) begin
        r_state   <= c_ST_IDLE;
        r_buttons <= '0;
        r_atk_cnt <= '0;
      end else begin
        r_atk_cnt <= r_atk_cnt + 1'b1;
        if (r_atk_cnt == c_HOLD_LAST) begin
          r_buttons <= '0;
        end
      end
    end else if (w_strobe) begin
      r_state   <= w_dec_state;
      r_buttons <= w_dec_buttons;
      r_atk_cnt <= '0;
    end
  end

  assign cpu_inputs = r_buttons;
  assign cpu_state  = r_state;

  // Inputs and constants the decision logic has no use for
  assign w_unused = ^{self_y, opp_y, finish[1], opp_action[6], btn(CENTER), btn(DOWN),
                      SHIELD_CODE, GROUND_Y};

endmodule
`default_nettype wire

// File: tb/tb_cpu_opponent.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_opponent
//  Description : Directed self-checking bench for cpu_opponent with short
//                timing parameters (period 8, hold 4, gap 4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_opponent;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [9:0] self_x, self_y, opp_x, opp_y;
  logic [3:0] self_health, self_shield;
  logic [6:0] opp_action;
  logic [1:0] finish;
  logic [6:0] cpu_inputs;
  logic [2:0] cpu_state;

  int          n_pass   = 0;
  int          n_checks = 0;
  int          m_timer  = 0;
  logic [15:0] m_lfsr   = 16'hACE1;

  always #5 clk = ~clk;

  cpu_opponent #(
    .DECIDE_PERIOD (8),
    .ATTACK_HOLD   (4),
    .ATTACK_GAP    (4),
    .ATTACK_RANGE  (80),
    .LOW_HEALTH    (4),
    .SEED          (16'hACE1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .self_x      (self_x),
    .self_y      (self_y),
    .opp_x       (opp_x),
    .opp_y       (opp_y),
    .self_health (self_health),
    .self_shield (self_shield),
    .opp_action  (opp_action),
    .finish      (finish),
    .cpu_inputs  (cpu_inputs),
    .cpu_state   (cpu_state)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic bit lfsr_ok(input int kind, input logic [15:0] l);
    case (kind)
      1:       return l[0] == 1'b1;
      2:       return l[2:1] == 2'b00;
      3:       return l[2:0] == 3'b000;
      4:       return l[2:0] != 3'b000;
      5:       return l[0] == 1'b0;
      6:       return l[2:1] != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  // One clock; model of timer and LFSR follows the edge just taken
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) begin
      m_timer = 0;
      m_lfsr  = 16'hACE1;
    end else begin
      m_timer = (m_timer == 7) ? 0 : m_timer + 1;
      m_lfsr  = lfsr_step(m_lfsr);
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic [6:0] eb, input logic [2:0] es);
    check({tag, "_btn"}, {9'd0, cpu_inputs}, {9'd0, eb});
    check({tag, "_st"}, {13'd0, cpu_state}, {13'd0, es});
  endtask

  // Park the DUT in IDLE and run to the clock before a strobe whose LFSR
  // value satisfies the requested condition
  task automatic to_strobe(input int kind);
    bit ok;
    ok = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      if (m_timer == 7 && lfsr_ok(kind, m_lfsr)) ok = 1'b1;
      else tick();
    end
    if (!ok) begin
      n_checks++;
      $error("FAIL strobe_wait_%0d: observed timeout expected matching strobe", kind);
    end
    enable = 1'b1;
  endtask

  task automatic decide(input string tag, input int kind, input logic [9:0] sx,
                        input logic [9:0] ox, input logic [6:0] act, input logic [3:0] hp,
                        input logic [3:0] sh, input logic [6:0] eb, input logic [2:0] es);
    to_strobe(kind);
    self_x = sx; opp_x = ox; opp_action = act; self_health = hp; self_shield = sh;
    tick();
    check_out(tag, eb, es);
  endtask

  initial begin
    logic [6:0] exp_b;
    reset = 1'b1; enable = 1'b1; finish = 2'b00;
    self_x = 10'd200; opp_x = 10'd600; self_y = 10'd300; opp_y = 10'd300;
    self_health = 4'd15; self_shield = 4'd0; opp_action = 7'd0;
    repeat (3) tick();
    check_out("reset", 7'b0000000, 3'd0);
    reset = 1'b0;

    // Far opponent to the right: idle until the first strobe, then approach
    for (int i = 0; i < 7; i++) begin
      tick();
      check_out("t1_pre", 7'b0000000, 3'd0);
    end
    exp_b = (m_lfsr[2:0] == 3'b000) ? 7'b0001000 : 7'b0000100;
    tick();
    check_out("t1_first", exp_b, (exp_b == 7'b0001000) ? 3'd5 : 3'd1);

    // Attack shaping: 4 high, 4 low, strobe at the end is dropped
    decide("t2_enter", 0, 10'd200, 10'd250, 7'd0, 4'd15, 4'd0, 7'b0100000, 3'd2);
    for (int i = 1; i < 4; i++) begin
      tick();
      check_out("t2_hold", 7'b0100000, 3'd2);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("t2_gap", 7'b0000000, 3'd2);
    end
    tick();
    check_out("t2_end", 7'b0000000, 3'd0);
    tick();
    check_out("t2_after", 7'b0000000, 3'd0);

    // Guard / shield interplay (facing bit must not disturb the code match)
    decide("t3_guard", 1, 10'd200, 10'd250, 7'h48, 4'd15, 4'd3, 7'b1000000, 3'd3);
    decide("t3_noshield", 0, 10'd200, 10'd250, 7'h08, 4'd15, 4'd0, 7'b0100000, 3'd2);
    decide("t3_lfsr0", 5, 10'd200, 10'd250, 7'h08, 4'd15, 4'd3, 7'b0100000, 3'd2);

    // Retreat and walls
    decide("t4_lwall", 2, 10'd143, 10'd150, 7'd0, 4'd2, 4'd0, 7'b1000000, 3'd3);
    decide("t4_retreat", 2, 10'd300, 10'd340, 7'd0, 4'd2, 4'd0, 7'b0000010, 3'd4);
    decide("t4_rwall", 2, 10'd704, 10'd650, 7'd0, 4'd2, 4'd0, 7'b1000000, 3'd3);
    decide("t4_rright", 2, 10'd703, 10'd650, 7'd0, 4'd2, 4'd0, 7'b0000100, 3'd4);
    decide("t4_nolfsr", 6, 10'd300, 10'd340, 7'd0, 4'd2, 4'd0, 7'b0100000, 3'd2);
    decide("t4_health4", 2, 10'd300, 10'd340, 7'd0, 4'd4, 4'd0, 7'b0100000, 3'd2);

    // Movement and the reach boundary
    decide("jump", 3, 10'd200, 10'd600, 7'd0, 4'd15, 4'd0, 7'b0001000, 3'd5);
    decide("appr_left", 4, 10'd600, 10'd200, 7'd0, 4'd15, 4'd0, 7'b0000010, 3'd1);
    decide("dist80", 4, 10'd200, 10'd280, 7'd0, 4'd15, 4'd0, 7'b0000100, 3'd1);
    decide("dist79", 0, 10'd200, 10'd279, 7'd0, 4'd15, 4'd0, 7'b0100000, 3'd2);

    // Game over two clocks into the hold
    decide("t5_enter", 0, 10'd200, 10'd250, 7'd0, 4'd15, 4'd0, 7'b0100000, 3'd2);
    tick();
    check_out("t5_hold", 7'b0100000, 3'd2);
    finish = 2'b01;
    tick();
    check_out("t5_abort", 7'b0000000, 3'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check_out("t5_stay", 7'b0000000, 3'd0);
    end
    finish = 2'b00;

    // Disable mid-attack
    decide("dis_enter", 0, 10'd200, 10'd250, 7'd0, 4'd15, 4'd0, 7'b0100000, 3'd2);
    enable = 1'b0;
    tick();
    check_out("dis_abort", 7'b0000000, 3'd0);
    enable = 1'b1;

    // Reset mid-attack restores timer and LFSR
    decide("rst_enter", 0, 10'd200, 10'd250, 7'd0, 4'd15, 4'd0, 7'b0100000, 3'd2);
    tick();
    reset = 1'b1;
    tick();
    check_out("rst_mid", 7'b0000000, 3'd0);
    reset = 1'b0;
    self_x = 10'd200; opp_x = 10'd600;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_out("rst_pre", 7'b0000000, 3'd0);
    end
    exp_b = (m_lfsr[2:0] == 3'b000) ? 7'b0001000 : 7'b0000100;
    tick();
    check_out("rst_first", exp_b, (exp_b == 7'b0001000) ? 3'd5 : 3'd1);

    // Random stimulus: button exclusivity and legal state codes
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        enable      = ($urandom_range(0, 9) != 0);
        finish      = ($urandom_range(0, 19) == 0) ? 2'b01 : 2'b00;
        self_x      = 10'($urandom_range(143, 704));
        opp_x       = ($urandom_range(0, 1) == 1) ? 10'(self_x + 10'($urandom_range(0, 90)))
                                                  : 10'($urandom_range(143, 704));
        opp_action  = ($urandom_range(0, 1) == 1) ? 7'h08 : 7'($urandom_range(0, 127));
        self_health = 4'($urandom_range(0, 15));
        self_shield = 4'($urandom_range(0, 3));
      end
      tick();
      check("rand_excl", {12'd0, cpu_inputs[2] & cpu_inputs[1], cpu_inputs[4], cpu_inputs[0],
                          (cpu_state > 3'd5)}, 16'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
